// File: rtl/reg_intf_pkg.sv
// Shared widths, opcode defaults and the bridge state encoding for the
// byte-stream register bridge.
package reg_intf_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;

    localparam logic [7:0] OP_WR_DEF = 8'h57;
    localparam logic [7:0] OP_RD_DEF = 8'h52;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_DATA_H,
        ST_DATA_L,
        ST_WRITE,
        ST_READ,
        ST_TX_H,
        ST_TX_L
    } bridge_state_t;

    // States in which an inbound byte may be taken.
    function automatic logic takes_rx(input bridge_state_t s);
        return s inside {ST_IDLE, ST_ADDR_H, ST_ADDR_L, ST_DATA_H, ST_DATA_L};
    endfunction

    // Counter width able to hold the value n (at least one bit).
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/reg_intf_byte_bridge_if.sv
// Signal bundle between the host byte link, the bridge and the register bus.
// slave = bridge view, master = host/register-file side.
interface reg_intf_byte_bridge_if;

    logic [7:0]                       rx_data;
    logic                             rx_valid;
    logic                             rx_ready;
    logic [7:0]                       tx_data;
    logic                             tx_valid;
    logic                             tx_ready;
    logic                             wr_en;
    logic                             rd_en;
    logic [reg_intf_pkg::ADDR_W-1:0]  addr;
    logic [reg_intf_pkg::DATA_W-1:0]  write_data;
    logic [reg_intf_pkg::DATA_W-1:0]  read_data;
    logic                             busy;
    logic                             err_pulse;

    modport slave (
        input  rx_data, rx_valid, tx_ready, read_data,
        output rx_ready, tx_data, tx_valid, wr_en, rd_en, addr, write_data,
               busy, err_pulse
    );

    modport master (
        output rx_data, rx_valid, tx_ready, read_data,
        input  rx_ready, tx_data, tx_valid, wr_en, rd_en, addr, write_data,
               busy, err_pulse
    );

endinterface

// File: rtl/reg_intf_timeout_cnt.sv
// Inter-byte idle counter: expire fires in the cycle the count would reach
// TIMEOUT_CYC, so a byte arriving in that same cycle still wins.
module reg_intf_timeout_cnt
    import reg_intf_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    localparam int CNT_W      = cnt_width(TIMEOUT_CYC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] last_cnt;

    assign last_cnt = limit - CNT_W'(1);

    always_comb begin
        count_next = count_reg + CNT_W'(1);
        if (clear || !enable || (limit == '0)) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expire = enable && !clear && (limit != '0) && (count_reg == last_cnt);

endmodule

// File: rtl/reg_intf_byte_bridge.sv
// Framed byte stream -> single-cycle register write/read strobes, with the
// read result returned as two bytes (high first) on the tx stream.
module reg_intf_byte_bridge
    import reg_intf_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 1024,
    parameter logic [7:0] OP_WR       = OP_WR_DEF,
    parameter logic [7:0] OP_RD       = OP_RD_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_intf_byte_bridge_if.slave bus
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYC);

    bridge_state_t       state_reg, state_next;
    logic                err_next;
    logic                rx_ready_int;
    logic                accept;
    logic                expire;
    logic                op_rd_reg;
    logic                wr_en_reg, rd_en_reg, tx_valid_reg, busy_reg, err_pulse_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   write_data_reg;
    logic [DATA_W-1:0]   hold_reg;

    assign rx_ready_int = takes_rx(state_reg);
    assign accept       = bus.rx_valid && rx_ready_int;

    reg_intf_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (rx_ready_int && (state_reg != ST_IDLE)),
        .limit  (CNT_W'(TIMEOUT_CYC)),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        err_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if ((bus.rx_data == OP_WR) || (bus.rx_data == OP_RD)) begin
                        state_next = ST_ADDR_H;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_ADDR_H: if (accept) state_next = ST_ADDR_L;
            ST_ADDR_L: if (accept) state_next = op_rd_reg ? ST_READ : ST_DATA_H;
            ST_DATA_H: if (accept) state_next = ST_DATA_L;
            ST_DATA_L: if (accept) state_next = ST_WRITE;
            ST_WRITE:  state_next = ST_IDLE;
            ST_READ:   state_next = ST_TX_H;
            ST_TX_H:   if (bus.tx_ready) state_next = ST_TX_L;
            ST_TX_L:   if (bus.tx_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        // Abandoned frame: drop back to IDLE without issuing a strobe.
        if (expire) begin
            state_next = ST_IDLE;
            err_next   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_reg      <= 1'b0;
            rd_en_reg      <= 1'b0;
            tx_valid_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            err_pulse_reg  <= 1'b0;
            op_rd_reg      <= 1'b0;
            addr_reg       <= '0;
            write_data_reg <= '0;
            hold_reg       <= '0;
        end else begin
            wr_en_reg     <= (state_next == ST_WRITE);
            rd_en_reg     <= (state_next == ST_READ);
            tx_valid_reg  <= (state_next == ST_TX_H) || (state_next == ST_TX_L);
            busy_reg      <= (state_next != ST_IDLE);
            err_pulse_reg <= err_next;
            if (accept) begin
                case (state_reg)
                    ST_IDLE:   op_rd_reg             <= (bus.rx_data == OP_RD);
                    ST_ADDR_H: addr_reg[13:8]        <= bus.rx_data[5:0];
                    ST_ADDR_L: addr_reg[7:0]         <= bus.rx_data;
                    ST_DATA_H: write_data_reg[15:8]  <= bus.rx_data;
                    ST_DATA_L: write_data_reg[7:0]   <= bus.rx_data;
                    default:   ;
                endcase
            end
            if (state_reg == ST_READ) begin
                hold_reg <= bus.read_data;
            end
        end
    end

    assign bus.rx_ready   = rx_ready_int;
    assign bus.tx_data    = (state_reg == ST_TX_L) ? hold_reg[7:0] : hold_reg[15:8];
    assign bus.tx_valid   = tx_valid_reg;
    assign bus.wr_en      = wr_en_reg;
    assign bus.rd_en      = rd_en_reg;
    assign bus.addr       = addr_reg;
    assign bus.write_data = write_data_reg;
    assign bus.busy       = busy_reg;
    assign bus.err_pulse  = err_pulse_reg;

endmodule

// File: tb/tb_reg_intf_byte_bridge.sv
// Directed bench for reg_intf_byte_bridge with a behavioural register file
// on the bus side and TIMEOUT_CYC reduced to 16.
module tb_reg_intf_byte_bridge;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_intf_byte_bridge_if bus ();

    reg_intf_byte_bridge #(
        .TIMEOUT_CYC (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Register file model and strobe monitor
    logic [15:0] mem [0:16383];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          err_cnt = 0;
    logic [13:0] last_wr_addr = '0;
    logic [15:0] last_wr_data = '0;
    logic [13:0] last_rd_addr = '0;

    assign bus.read_data = mem[bus.addr];

    always @(posedge clk) begin
        if (bus.wr_en) begin
            mem[bus.addr] <= bus.write_data;
            wr_cnt        <= wr_cnt + 1;
            last_wr_addr  <= bus.addr;
            last_wr_data  <= bus.write_data;
        end
        if (bus.rd_en) begin
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= bus.addr;
        end
        if (bus.err_pulse) err_cnt <= err_cnt + 1;
        if (bus.wr_en && bus.rd_en) check("strobe_exclusive", 1, 0);
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rx_ready) check("rx_ready_wait", 0, 1);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b);
        int n = 0;
        b = 8'h00;
        @(negedge clk);
        bus.tx_ready = 1'b1;
        while (!bus.tx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.tx_valid) begin
            check("tx_valid_wait", 0, 1);
        end else begin
            b = bus.tx_data;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_read(input logic [7:0] ah, input logic [7:0] al,
                           input logic [15:0] exp, input string tag);
        logic [7:0] hi, lo;
        int r0;
        r0 = rd_cnt;
        send_byte(8'h52);
        send_byte(ah);
        send_byte(al);
        recv_byte(hi);
        recv_byte(lo);
        check(tag, {hi, lo}, exp);
        check("busy_after_tx", bus.busy, 0);
        check("rd_strobe_count", rd_cnt - r0, 1);
        check("rd_addr", last_rd_addr, {ah[5:0], al});
    endtask

    task automatic send_write(input logic [7:0] ah, input logic [7:0] al,
                              input logic [7:0] dh, input logic [7:0] dl);
        send_byte(8'h57);
        send_byte(ah);
        send_byte(al);
        send_byte(dh);
        send_byte(dl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0, e0, n;
        logic [7:0] hi, lo;

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;

        // Reset values while held in reset
        repeat (3) @(negedge clk);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_rd_en", bus.rd_en, 0);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_err", bus.err_pulse, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_addr", bus.addr, 0);
        check("rst_wdata", bus.write_data, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_rx_ready", bus.rx_ready, 1);
        rst = 1'b1;

        // Write 0x0040 to 0x101
        w0 = wr_cnt;
        send_write(8'h01, 8'h01, 8'h00, 8'h40);
        check("wr_strobe", bus.wr_en, 1);
        check("wr_strobe_addr", bus.addr, 14'h101);
        check("wr_strobe_data", bus.write_data, 16'h0040);
        check("wr_no_rd", bus.rd_en, 0);
        @(posedge clk); #1;
        check("wr_one_cycle", bus.wr_en, 0);
        check("wr_idle_busy", bus.busy, 0);
        repeat (2) @(posedge clk); #1;
        check("wr_count", wr_cnt - w0, 1);
        do_read(8'h01, 8'h01, 16'h0040, "conv_width_readback");

        // Preload 0x108 and read it back
        send_write(8'h01, 8'h08, 8'h02, 8'h03);
        do_read(8'h01, 8'h08, 16'h0203, "read_0x108");

        // Read under tx backpressure
        r0 = rd_cnt;
        bus.tx_ready = 1'b0;
        send_byte(8'h52);
        send_byte(8'h01);
        send_byte(8'h08);
        n = 0;
        while (!bus.tx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_tx_valid", bus.tx_valid, 1);
            check("bp_tx_data", bus.tx_data, 8'h02);
            check("bp_rx_ready", bus.rx_ready, 0);
        end
        recv_byte(hi);
        recv_byte(lo);
        check("bp_bytes", {hi, lo}, 16'h0203);
        check("bp_rd_count", rd_cnt - r0, 1);

        // Bad opcode then an immediate good frame
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        send_byte(8'hFF);
        check("badop_err", bus.err_pulse, 1);
        check("badop_busy", bus.busy, 0);
        send_byte(8'h57);
        check("badop_err_one_cycle", bus.err_pulse, 0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        repeat (2) @(posedge clk); #1;
        check("badop_wr_count", wr_cnt - w0, 1);
        check("badop_rd_count", rd_cnt - r0, 0);
        check("badop_err_count", err_cnt - e0, 1);
        check("badop_wr_addr", last_wr_addr, 14'h102);
        check("badop_wr_data", last_wr_data, 16'h1234);

        // Inter-byte timeout after 57,01
        w0 = wr_cnt;
        send_byte(8'h57);
        send_byte(8'h01);
        check("to_busy_mid", bus.busy, 1);
        repeat (15) @(posedge clk); #1;
        check("to_not_yet", bus.err_pulse, 0);
        check("to_still_busy", bus.busy, 1);
        @(posedge clk); #1;
        check("to_err", bus.err_pulse, 1);
        check("to_idle", bus.busy, 0);
        check("to_rx_ready", bus.rx_ready, 1);
        @(posedge clk); #1;
        check("to_err_one_cycle", bus.err_pulse, 0);
        check("to_no_write", wr_cnt - w0, 0);
        do_read(8'h01, 8'h08, 16'h0203, "read_after_timeout");

        // ADDR_H[7:6] are ignored
        do_read(8'hC1, 8'h01, 16'h0040, "addr_hi_ignored");

        // Reset mid-frame
        w0 = wr_cnt;
        send_byte(8'h57);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mr_wr_en", bus.wr_en, 0);
        check("mr_busy", bus.busy, 0);
        check("mr_addr", bus.addr, 0);
        check("mr_wdata", bus.write_data, 0);
        check("mr_tx_valid", bus.tx_valid, 0);
        check("mr_rx_ready", bus.rx_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("mr_no_write", wr_cnt - w0, 0);
        do_read(8'h01, 8'h01, 16'h0040, "read_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_intf_byte_bridge.md
Name: reg_intf_byte_bridge

Overview:
Byte-stream to register-bus bridge sitting directly upstream of the CONV register file (and sibling register files sharing the bus). Accepts framed command bytes from the host link (UART/SPI deserialiser) over a valid/ready handshake. Issues single-cycle wr_en/rd_en strobes with addr/write_data, and returns read data as two bytes on an outbound valid/ready stream. Includes an inter-byte timeout and bad-opcode detection.

Parameters:
TIMEOUT_CYC, 1024, max idle cycles between bytes inside a frame before abort; 0 disables timeout
OP_WR, 8'h57, write opcode byte
OP_RD, 8'h52, read opcode byte

Ports:
clk  in  1  system clock
rst  in  1  reset: asynchronous, active-low (0 = reset)
rx_data  in  8  inbound command byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  bridge accepts rx byte this cycle
tx_data  out  8  outbound read-response byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  downstream accepts tx byte
wr_en  out  1  register write strobe, one cycle
rd_en  out  1  register read strobe, one cycle
addr  out  14  register address
write_data  out  16  register write data
read_data  in  16  combinational read data from register files (OR of read_data_* buses)
busy  out  1  high in any state other than IDLE
err_pulse  out  1  one-cycle pulse on bad opcode or timeout

Behaviour:
- Frames: write = OP_WR, ADDR_H, ADDR_L, DATA_H, DATA_L; read = OP_RD, ADDR_H, ADDR_L. ADDR_H[7:6] ignored; addr = {ADDR_H[5:0], ADDR_L}.
- Byte accepted on a rising edge where rx_valid && rx_ready.
- States: IDLE -> ADDR_H -> ADDR_L -> (write: DATA_H -> DATA_L -> WRITE) / (read: READ -> TX_H -> TX_L) -> IDLE.
- rx_ready = 1 in IDLE, ADDR_H, ADDR_L, DATA_H, DATA_L; 0 in WRITE, READ, TX_H, TX_L.
- IDLE: byte == OP_WR or OP_RD -> ADDR_H, latch op. Any other byte -> consumed, err_pulse next cycle, stay IDLE.
- addr updates only in ADDR_H/ADDR_L. write_data updates only in DATA_H/DATA_L. Both hold their value between frames.
- WRITE: wr_en = 1 for exactly one cycle. Starts the cycle after the DATA_L byte is accepted; regfile captures on the following edge. Then IDLE.
- READ: rd_en = 1 for one cycle. read_data captured into a 16-bit tx holding register on that edge. -> TX_H.
- TX_H: tx_valid = 1, tx_data = hold[15:8]; on tx_ready -> TX_L.
- TX_L: tx_valid = 1, tx_data = hold[7:0]; on tx_ready -> IDLE.
- tx_data stable while tx_valid && !tx_ready. No tx timeout; backpressure may persist indefinitely.
- Timeout: counter clears on every accepted byte. It increments each cycle in ADDR_H, ADDR_L, DATA_H, DATA_L while no byte is accepted. When the count reaches TIMEOUT_CYC: -> IDLE, err_pulse, no strobe issued. The counter is held at 0 in IDLE, WRITE, READ, TX_*.
- wr_en, rd_en, tx_valid and err_pulse are registered outputs (no combinational path from rx_* to them). rx_ready is decoded from state only.
- Reset values: state IDLE; wr_en, rd_en, tx_valid, err_pulse, busy = 0; addr, write_data, tx_data, hold = 0; rx_ready = 1 after reset release.
- Reset mid-frame or mid-tx: frame discarded, no strobe, tx byte dropped.
- wr_en and rd_en are never high in the same cycle. At most one strobe per frame.

Decomposition:
- reg_intf_pkg: ADDR_W=14, DATA_W=16, OP_WR/OP_RD defaults, bridge state enum typedef.
- One sub-module, reg_intf_timeout_cnt: counter with clear/enable/limit inputs and expire output, parameterised by TIMEOUT_CYC.

Test Plan:
- Write: rx 57,01,01,00,40 with rx_valid held -> one wr_en cycle with addr=14'h101, write_data=16'h0040; CONV data width register reads back 0x0040.
- Read: preload reg 0x108 = 16'h0203; rx 52,01,08 -> one rd_en with addr=14'h108, then tx bytes 02 then 03; busy low after second tx handshake.
- Backpressure: read with tx_ready=0 for 5 cycles -> tx_valid stays 1, tx_data=02 stable, rx_ready=0 throughout; no second rd_en.
- Bad opcode: rx FF -> err_pulse one cycle, no wr_en/rd_en; an immediately following frame 57,01,02,12,34 writes 0x1234 to 0x102.
- Timeout (TIMEOUT_CYC=16): rx 57,01 then idle 16 cycles -> err_pulse, state IDLE, no wr_en; next byte 52 is taken as an opcode.
- Reset: assert rst=0 after rx 57,01,01,00 -> all outputs at reset values; no wr_en after release.
